piezo_tone_driver: RTL and testbench

- Downstream stage of the lullaby note sequencer. Replaces the bare piezo tone block.
- Samples the sequencer's 13-bit one-hot note code on each beat tick and drives a 50%-duty square wave on the piezo at the note's pitch.
- Inserts a short silent articulation gap at every beat, so repeated identical notes are heard as separate notes.
- Sits between the lullaby sequencer (beat code) and the board's piezo pin. Shares the beat-rate divider tick with the sequencer.

---
 rtl/tone_pkg.sv | 56 +++++
 rtl/onehot_prio_enc.sv | 22 ++
 rtl/piezo_tone_driver.sv | 134 +++++++++++++
 tb/tb_piezo_tone_driver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared note definitions for the lullaby sequencer and the piezo tone driver.
package tone_pkg;

  localparam int unsigned NOTE_W = 13;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned HALF_W = 11;

  localparam logic [NOTE_W-1:0] NOTE_REST = 13'd0;

  typedef enum logic [IDX_W-1:0] {
    NOTE_C4  = 4'd0,
    NOTE_CS4 = 4'd1,
    NOTE_D4  = 4'd2,
    NOTE_DS4 = 4'd3,
    NOTE_E4  = 4'd4,
    NOTE_F4  = 4'd5,
    NOTE_FS4 = 4'd6,
    NOTE_G4  = 4'd7,
    NOTE_GS4 = 4'd8,
    NOTE_A4  = 4'd9,
    NOTE_AS4 = 4'd10,
    NOTE_B4  = 4'd11,
    NOTE_C5  = 4'd12
  } note_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_TONE = 2'd2
  } tone_state_e;

  // Rounded clk_hz / (2*f); pitches are held in milli-hertz to keep the rounding exact.
  function automatic int unsigned half_period(int unsigned clk_hz, int unsigned idx);
    longint unsigned f_mhz;
    longint unsigned num;
    case (idx)
      32'd0:   f_mhz = 64'd261626;
      32'd1:   f_mhz = 64'd277183;
      32'd2:   f_mhz = 64'd293665;
      32'd3:   f_mhz = 64'd311127;
      32'd4:   f_mhz = 64'd329628;
      32'd5:   f_mhz = 64'd349228;
      32'd6:   f_mhz = 64'd369994;
      32'd7:   f_mhz = 64'd391995;
      32'd8:   f_mhz = 64'd415305;
      32'd9:   f_mhz = 64'd440000;
      32'd10:  f_mhz = 64'd466164;
      32'd11:  f_mhz = 64'd493883;
      32'd12:  f_mhz = 64'd523251;
      default: f_mhz = 64'd261626;
    endcase
    num = 64'(clk_hz) * 64'd1000 + f_mhz;
    return 32'(num / (64'd2 * f_mhz));
  endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-set-bit encoder for the 13-bit note code, with rest and multi-hot flags.
module onehot_prio_enc
  import tone_pkg::*;
(
  input  logic [NOTE_W-1:0] code_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o,
  output logic              multi_o
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = NOTE_W - 1; i >= 0; i--) begin
      if (code_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = (code_i != NOTE_REST);
  assign multi_o = ((code_i & (code_i - NOTE_W'(1))) != NOTE_REST);

endmodule

// File: rtl/piezo_tone_driver.sv
// Beat-synchronous piezo square-wave generator with a silent articulation gap per beat.
module piezo_tone_driver
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 1000000,
  parameter int unsigned GAP_CYCLES = 20000,
  parameter int unsigned OCT_SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] play_sound,
  input  logic              beat_tick,
  output logic              piezo,
  output logic              busy,
  output logic              note_err
);

  localparam int unsigned GAP_W   = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int unsigned TBL_N   = 16;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  if (OCT_SHIFT > 2 || CLK_HZ < 100000) begin : g_bad_param
    $error("piezo_tone_driver: OCT_SHIFT must be 0..2 and CLK_HZ at least 100000");
  end

  // Constant half-period table, padded so any 4-bit index is in range.
  logic [HALF_W-1:0] half_tbl [TBL_N];
  for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
    if (32'(g) < NOTE_W) begin : g_note
      assign half_tbl[g] = HALF_W'(half_period(CLK_HZ, 32'(g)) >> OCT_SHIFT);
    end else begin : g_pad
      assign half_tbl[g] = '0;
    end
  end

  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid;
  logic             enc_multi;

  onehot_prio_enc u_enc (
    .code_i  (play_sound),
    .idx_o   (enc_idx),
    .valid_o (enc_valid),
    .multi_o (enc_multi)
  );

  tone_state_e       state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              piezo_q, piezo_d;
  logic              busy_q;
  logic              note_err_q, note_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      half_cnt_q <= '0;
      half_q     <= '0;
      piezo_q    <= 1'b0;
      busy_q     <= 1'b0;
      note_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      half_cnt_q <= half_cnt_d;
      half_q     <= half_d;
      piezo_q    <= piezo_d;
      busy_q     <= (state_d != ST_IDLE);
      note_err_q <= note_err_d;
    end
  end

  // A beat tick overrides whatever the current state would do this edge.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    half_cnt_d = half_cnt_q;
    half_d     = half_q;
    piezo_d    = piezo_q;
    note_err_d = 1'b0;

    if (beat_tick) begin
      gap_cnt_d  = '0;
      half_cnt_d = '0;
      if (enc_valid) begin
        half_d     = half_tbl[enc_idx];
        note_err_d = enc_multi;
        if (GAP_CYCLES == 0) begin
          state_d = ST_TONE;
          piezo_d = 1'b1;
        end else begin
          state_d = ST_GAP;
          piezo_d = 1'b0;
        end
      end else begin
        state_d = ST_IDLE;
        piezo_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_GAP: begin
          piezo_d = 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            state_d    = ST_TONE;
            piezo_d    = 1'b1;
            gap_cnt_d  = '0;
            half_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        ST_TONE: begin
          if (half_cnt_q == half_q - HALF_W'(1)) begin
            piezo_d    = ~piezo_q;
            half_cnt_d = '0;
          end else begin
            half_cnt_d = half_cnt_q + HALF_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          piezo_d = 1'b0;
        end
      endcase
    end
  end

  assign piezo    = piezo_q;
  assign busy     = busy_q;
  assign note_err = note_err_q;

endmodule

// File: tb/tb_piezo_tone_driver.sv
// Directed bench for piezo_tone_driver: one instance with a 4-cycle gap, one transposed two octaves with no gap.
module tb_piezo_tone_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] play_sound;
  logic        beat_tick;
  logic        piezo_a, busy_a, note_err_a;
  logic        piezo_b, busy_b, note_err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piezo_tone_driver #(.CLK_HZ(1000000), .GAP_CYCLES(4), .OCT_SHIFT(0)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .play_sound (play_sound),
    .beat_tick  (beat_tick),
    .piezo      (piezo_a),
    .busy       (busy_a),
    .note_err   (note_err_a)
  );

  piezo_tone_driver #(.CLK_HZ(1000000), .GAP_CYCLES(0), .OCT_SHIFT(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .play_sound (play_sound),
    .beat_tick  (beat_tick),
    .piezo      (piezo_b),
    .busy       (busy_b),
    .note_err   (note_err_b)
  );

  // Issue a one-cycle beat tick; returns at the falling edge right after the tick edge.
  task automatic tick(input logic [12:0] code);
    @(negedge clk);
    play_sound = code;
    beat_tick  = 1'b1;
    @(negedge clk);
    beat_tick  = 1'b0;
  endtask

  // Count consecutive falling-edge samples at level lvl, starting with the current one.
  task automatic measure(input bit sel, input logic lvl, output int len);
    len = 0;
    while (len < 5000 && ((sel ? piezo_b : piezo_a) === lvl)) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    play_sound = 13'h0200;
    beat_tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      beat_tick = ~beat_tick;
      n_vec++;
      if (piezo_a !== 1'b0 || busy_a !== 1'b0 || note_err_a !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc %0d: piezo=%b busy=%b note_err=%b required 0 0 0",
                 i, piezo_a, busy_a, note_err_a);
      end
    end
    @(negedge clk);
    beat_tick = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (piezo_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: piezo=%b busy=%b required 0 0", piezo_a, busy_a);
    end
  endtask

  task automatic test_a4_pitch;
    int len;
    tick(13'h0200);
    n_vec++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL a4_busy: got %b required 1", busy_a);
    end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 4) begin n_err++; $display("FAIL a4_gap: got %0d cycles required 4", len); end
    measure(1'b0, 1'b1, len);
    n_vec++;
    if (len != 1136) begin n_err++; $display("FAIL a4_high: got %0d cycles required 1136", len); end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 1136) begin n_err++; $display("FAIL a4_low: got %0d cycles required 1136", len); end
  endtask

  task automatic test_repeat_note;
    int len;
    repeat (500) @(negedge clk);
    n_vec++;
    if (piezo_a !== 1'b1) begin n_err++; $display("FAIL rep_mid_high: got %b required 1", piezo_a); end
    tick(13'h0200);
    n_vec++;
    if (piezo_a !== 1'b0) begin n_err++; $display("FAIL rep_drop: got %b required 0", piezo_a); end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 4) begin n_err++; $display("FAIL rep_gap: got %0d cycles required 4", len); end
    measure(1'b0, 1'b1, len);
    n_vec++;
    if (len != 1136) begin n_err++; $display("FAIL rep_high: got %0d cycles required 1136", len); end
  endtask

  task automatic test_rest_multi;
    int len;
    tick(13'h0000);
    n_vec++;
    if (piezo_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL rest: piezo=%b busy=%b required 0 0", piezo_a, busy_a);
    end
    tick(13'h1001);
    n_vec++;
    if (note_err_a !== 1'b1) begin n_err++; $display("FAIL multi_err_pulse: got %b required 1", note_err_a); end
    @(negedge clk);
    n_vec++;
    if (note_err_a !== 1'b0) begin n_err++; $display("FAIL multi_err_clear: got %b required 0", note_err_a); end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 3) begin n_err++; $display("FAIL multi_gap_rest: got %0d cycles required 3", len); end
    measure(1'b0, 1'b1, len);
    n_vec++;
    if (len != 1911) begin n_err++; $display("FAIL multi_c4_high: got %0d cycles required 1911", len); end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 1911) begin n_err++; $display("FAIL multi_c4_low: got %0d cycles required 1911", len); end
  endtask

  task automatic test_octave_nogap;
    int len;
    tick(13'h1000);
    n_vec++;
    if (piezo_b !== 1'b1 || busy_b !== 1'b1) begin
      n_err++;
      $display("FAIL oct_rise: piezo=%b busy=%b required 1 1", piezo_b, busy_b);
    end
    measure(1'b1, 1'b1, len);
    n_vec++;
    if (len != 239) begin n_err++; $display("FAIL oct_high: got %0d cycles required 239", len); end
    measure(1'b1, 1'b0, len);
    n_vec++;
    if (len != 239) begin n_err++; $display("FAIL oct_low: got %0d cycles required 239", len); end
    measure(1'b1, 1'b1, len);
    n_vec++;
    if (len != 239) begin n_err++; $display("FAIL oct_high2: got %0d cycles required 239", len); end
  endtask

  task automatic test_code_change;
    int len;
    tick(13'h0001);
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 4) begin n_err++; $display("FAIL chg_gap: got %0d cycles required 4", len); end
    play_sound = 13'h0010;
    measure(1'b0, 1'b1, len);
    n_vec++;
    if (len != 1911) begin n_err++; $display("FAIL chg_hold_high: got %0d cycles required 1911", len); end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 1911) begin n_err++; $display("FAIL chg_hold_low: got %0d cycles required 1911", len); end
    tick(13'h0010);
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 4) begin n_err++; $display("FAIL chg_e4_gap: got %0d cycles required 4", len); end
    measure(1'b0, 1'b1, len);
    n_vec++;
    if (len != 1517) begin n_err++; $display("FAIL chg_e4_high: got %0d cycles required 1517", len); end
    measure(1'b0, 1'b0, len);
    n_vec++;
    if (len != 1517) begin n_err++; $display("FAIL chg_e4_low: got %0d cycles required 1517", len); end
  endtask

  task automatic test_reset_mid_tone;
    n_vec++;
    if (piezo_a !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre: got %b required 1", piezo_a); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (piezo_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: piezo=%b busy=%b required 0 0", piezo_a, busy_a);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (piezo_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after: piezo=%b busy=%b required 0 0", piezo_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_a4_pitch();
    test_repeat_note();
    test_rest_multi();
    test_octave_nogap();
    test_code_change();
    test_reset_mid_tone();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
